// File: rtl/mul_sched.sv
// Round-robin two-port scheduler for the shared 32x32 multiplier core, with operand stage and result buffer.
// Optional statistics counters are built only when MUL_SCHED_STATS_EN is defined.
module mul_sched #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_x0,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_y0,
    input  logic [31:0]      req_y1,
    input  logic [1:0]       req_signed,
    input  logic [1:0]       req_high,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    output logic [31:0]      m_x,
    output logic [31:0]      m_y,
    output logic             m_signed,
    output logic             m_high,
    input  logic [31:0]      m_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_result,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_stall
);

    logic             vld_p1;
    logic             id_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             vld_p2;
    logic             rr;
    logic             s2_free;
    logic             s1_adv;
    logic             s1_free;
    logic             accept;
    logic             acc_id;

    function automatic logic [1:0] rr_grant(input logic [1:0] v, input logic ptr);
        if (v == 2'b11)
            return ptr ? 2'b10 : 2'b01;
        return v;
    endfunction

    assign s2_free   = !vld_p2 || resp_ready;
    assign s1_adv    = vld_p1 && s2_free;
    assign s1_free   = !vld_p1 || s1_adv;
    assign req_ready = rr_grant(req_valid, rr) & {2{s1_free && !flush && resetn}};
    assign accept    = |(req_valid & req_ready);
    assign acc_id    = req_ready[1];
    assign resp_valid = vld_p2;

    // Stage 1: granted operands held for the combinational multiplier core
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            rr       <= 1'b0;
            id_p1    <= 1'b0;
            tag_p1   <= '0;
            m_x      <= '0;
            m_y      <= '0;
            m_signed <= 1'b0;
            m_high   <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            rr     <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            rr       <= !acc_id;
            id_p1    <= acc_id;
            tag_p1   <= acc_id ? req_tag1 : req_tag0;
            m_x      <= acc_id ? req_x1 : req_x0;
            m_y      <= acc_id ? req_y1 : req_y0;
            m_signed <= req_signed[acc_id];
            m_high   <= req_high[acc_id];
        end else if (s1_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 2: captured product half, returned with its origin
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p2      <= 1'b0;
            resp_id     <= 1'b0;
            resp_tag    <= '0;
            resp_result <= '0;
        end else if (flush) begin
            vld_p2 <= 1'b0;
        end else if (s1_adv) begin
            vld_p2      <= 1'b1;
            resp_id     <= id_p1;
            resp_tag    <= tag_p1;
            resp_result <= m_result;
        end else if (resp_ready) begin
            vld_p2 <= 1'b0;
        end
    end

`ifdef MUL_SCHED_STATS_EN
    // Handshakes in a flush cycle are ignored, so they are not counted as completed ops
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (vld_p2 && resp_ready && !flush)
                stat_ops <= stat_ops + 32'd1;
            if (vld_p2 && !resp_ready)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`else
    assign stat_ops   = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched; models the combinational multiplier core and checks hand-computed results.
module tb_mul_sched;

    localparam int TAG_W = 4;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [31:0]      req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
    logic [1:0]       req_signed = '0, req_high = '0;
    logic [TAG_W-1:0] req_tag0 = '0, req_tag1 = '0;
    logic [31:0]      m_x, m_y;
    logic             m_signed, m_high;
    logic [31:0]      m_result;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_result;
    logic [31:0]      stat_ops, stat_stall;

    mul_sched #(.TAG_W(TAG_W)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .req_signed(req_signed), .req_high(req_high),
        .req_tag0(req_tag0), .req_tag1(req_tag1),
        .m_x(m_x), .m_y(m_y), .m_signed(m_signed), .m_high(m_high),
        .m_result(m_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_tag(resp_tag), .resp_result(resp_result),
        .stat_ops(stat_ops), .stat_stall(stat_stall)
    );

    always #5 clock = ~clock;

    // Multiplier core model: extend per m_signed, keep low 64 bits, select half
    logic [63:0] xe, ye, prod;
    always_comb begin
        xe   = m_signed ? {{32{m_x[31]}}, m_x} : {32'b0, m_x};
        ye   = m_signed ? {{32{m_y[31]}}, m_y} : {32'b0, m_y};
        prod = xe * ye;
    end
    assign m_result = m_high ? prod[63:32] : prod[31:0];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_one(input int p, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic h, input logic [3:0] tg,
                           input logic [31:0] expv);
        resp_ready = 1'b1;
        if (p == 0) begin
            req_x0 = x; req_y0 = y; req_tag0 = tg;
            req_valid = 2'b01;
        end else begin
            req_x1 = x; req_y1 = y; req_tag1 = tg;
            req_valid = 2'b10;
        end
        req_signed[p] = s;
        req_high[p]   = h;
        #1;
        check("one ready", 32'(req_ready), (p == 0) ? 32'd1 : 32'd2);
        tick;
        req_valid = 2'b00;
        check("one m_x", m_x, x);
        check("one m_y", m_y, y);
        check("one m_sel", 32'({m_signed, m_high}), 32'({s, h}));
        check("one early vld", 32'(resp_valid), 32'd0);
        tick;
        check("one vld", 32'(resp_valid), 32'd1);
        check("one result", resp_result, expv);
        check("one id", 32'(resp_id), 32'(p));
        check("one tag", 32'(resp_tag), 32'(tg));
        tick;
        check("one drained", 32'(resp_valid), 32'd0);
    endtask

    task automatic set_op0(input int k);
        req_x0 = 32'(k + 1);
        req_y0 = 32'd10;
        req_tag0 = 4'(k);
        req_signed[0] = 1'b0;
        req_high[0] = 1'b0;
    endtask

    initial begin
        int nacc;
        int nresp;
        logic acc;

        // Reset state
        req_valid = 2'b11;
        #2;
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst vld", 32'(resp_valid), 32'd0);
        check("rst id", 32'(resp_id), 32'd0);
        check("rst tag", 32'(resp_tag), 32'd0);
        check("rst result", resp_result, 32'd0);
        check("rst m_x", m_x, 32'd0);
        check("rst m_y", m_y, 32'd0);
        check("rst m_sel", 32'({m_signed, m_high}), 32'd0);
        check("rst ops", stat_ops, 32'd0);
        check("rst stall", stat_stall, 32'd0);
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Single ops: signed and unsigned, both halves
        run_one(0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, 4'd3, 32'hFFFFFFFF);
        run_one(0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 4'd3, 32'hFFFFFFFE);
        run_one(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd5, 32'hFFFFFFFE);
        run_one(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd5, 32'h00000001);

        // Both ports continuously valid: alternating grants, one response per cycle
        resp_ready = 1'b1;
        req_x0 = 32'd3; req_y0 = 32'd5; req_tag0 = 4'hA;
        req_x1 = 32'd7; req_y1 = 32'd11; req_tag1 = 4'hB;
        req_signed = 2'b00; req_high = 2'b00;
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick;
            if (i > 0) begin
                check("rr vld", 32'(resp_valid), 32'd1);
                check("rr id", 32'(resp_id), 32'((i - 1) % 2));
                check("rr result", resp_result, ((i - 1) % 2 == 1) ? 32'd77 : 32'd15);
                check("rr tag", 32'(resp_tag), ((i - 1) % 2 == 1) ? 32'hB : 32'hA);
            end
        end
        req_valid = 2'b00;
        tick;
        check("rr last vld", 32'(resp_valid), 32'd1);
        check("rr last id", 32'(resp_id), 32'd1);
        check("rr last result", resp_result, 32'd77);
        tick;
        check("rr drained", 32'(resp_valid), 32'd0);

        // Backpressure: 4-op stream on port 0 with resp_ready low for 5 cycles
        resp_ready = 1'b0;
        nacc = 0;
        nresp = 0;
        set_op0(0);
        req_valid = 2'b01;
        #1;
        for (int c = 0; c < 5; c++) begin
            acc = req_valid[0] & req_ready[0];
            tick;
            if (acc) begin
                nacc++;
                if (nacc < 4) set_op0(nacc);
                else req_valid = 2'b00;
            end
            #1;
            if (c == 2) check("bp held mid", resp_result, 32'd10);
        end
        check("bp accepted", 32'(nacc), 32'd2);
        check("bp full ready", 32'(req_ready), 32'd0);
        check("bp vld", 32'(resp_valid), 32'd1);
        check("bp held result", resp_result, 32'd10);
        check("bp held tag", 32'(resp_tag), 32'd0);
`ifdef MUL_SCHED_STATS_EN
        check("bp stall", stat_stall, 32'd3);
`endif
        resp_ready = 1'b1;
        #1;
        for (int c = 0; c < 20 && nresp < 4; c++) begin
            if (resp_valid) begin
                check("bp result", resp_result, 32'((nresp + 1) * 10));
                check("bp tag", 32'(resp_tag), 32'(nresp));
                nresp++;
            end
            acc = req_valid[0] & req_ready[0];
            tick;
            if (acc) begin
                nacc++;
                if (nacc < 4) set_op0(nacc);
                else req_valid = 2'b00;
            end
            #1;
        end
        check("bp responses", 32'(nresp), 32'd4);
        check("bp total accepted", 32'(nacc), 32'd4);
        tick;
        check("bp drained", 32'(resp_valid), 32'd0);
`ifdef MUL_SCHED_STATS_EN
        check("bp ops", stat_ops, 32'd14);
`endif

        // Flush with both stages valid; pointer returns to port 0
        resp_ready = 1'b0;
        req_x0 = 32'd2; req_y0 = 32'd3; req_tag0 = 4'd1;
        req_valid = 2'b01;
        #1;
        tick;
        req_x0 = 32'd4; req_y0 = 32'd5; req_tag0 = 4'd2;
        #1;
        tick;
        req_x0 = 32'd6; req_y0 = 32'd7; req_tag0 = 4'd6;
        req_x1 = 32'd8; req_y1 = 32'd9; req_tag1 = 4'd7;
        req_valid = 2'b11;
        #1;
        check("fl full ready", 32'(req_ready), 32'd0);
        check("fl pre vld", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        resp_ready = 1'b1;
        #1;
        check("fl ready", 32'(req_ready), 32'd0);
        tick;
        flush = 1'b0;
        #1;
        check("fl vld cleared", 32'(resp_valid), 32'd0);
        check("fl port0 prio", 32'(req_ready), 32'd1);
        tick;
        req_valid = 2'b00;
        check("fl no stale resp", 32'(resp_valid), 32'd0);
        tick;
        check("fl new vld", 32'(resp_valid), 32'd1);
        check("fl new result", resp_result, 32'd42);
        check("fl new tag", 32'(resp_tag), 32'd6);
        check("fl new id", 32'(resp_id), 32'd0);
        tick;
        check("fl drained", 32'(resp_valid), 32'd0);
`ifdef MUL_SCHED_STATS_EN
        check("fl ops", stat_ops, 32'd15);
`endif

        // Asynchronous reset with ops in flight
        resp_ready = 1'b1;
        req_x1 = 32'h10; req_y1 = 32'h10; req_tag1 = 4'd9;
        req_signed[1] = 1'b0; req_high[1] = 1'b0;
        req_valid = 2'b10;
        #1;
        tick;
        req_tag1 = 4'd10;
        tick;
        check("ar pre vld", 32'(resp_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("ar vld", 32'(resp_valid), 32'd0);
        check("ar ready", 32'(req_ready), 32'd0);
        check("ar m_x", m_x, 32'd0);
        check("ar tag", 32'(resp_tag), 32'd0);
        check("ar ops", stat_ops, 32'd0);
        req_valid = 2'b00;
        resetn = 1'b1;
        run_one(0, 32'h12345678, 32'h10, 1'b0, 1'b0, 4'hC, 32'h23456780);
        run_one(0, 32'h12345678, 32'h10, 1'b0, 1'b1, 4'hD, 32'h00000001);
        run_one(1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 4'hF, 32'h40000000);
`ifdef MUL_SCHED_STATS_EN
        check("end ops", stat_ops, 32'd3);
`else
        check("end ops", stat_ops, 32'd0);
        check("end stall", stat_stall, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
